// File: rtl/avalon_pio_pkg.sv
// Shared constants for the bidirectional PIO: register word addresses and
// edge-capture mode encodings.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_bidir_pio_if.sv
// Avalon-MM slave port of the PIO: fixed-latency, no waitrequest.
interface avalon_bidir_pio_if;

  // Handshake: a write is accepted on every clock where chipselect && !write_n;
  // there is no back-pressure. readdata is registered every cycle from the
  // address alone and is valid on the clock after the address is presented.
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_sync.sv
// WIDTH-bit, SYNC_STAGES-deep flop synchroniser for asynchronous pin inputs.
module pio_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] ff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/avalon_bidir_pio.sv
// Avalon-MM bidirectional PIO: per-bit direction, optional open-drain drive,
// atomic set/clear, synchronised inputs, sticky edge capture and masked irq.
module avalon_bidir_pio
  import avalon_pio_pkg::*;
#(
  parameter int             WIDTH       = 1,
  parameter int             SYNC_STAGES = 2,
  parameter int             EDGE_TYPE   = 2,
  parameter int             OPEN_DRAIN  = 0,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic               clk,
  input  logic               reset,
  avalon_bidir_pio_if.slave  bus,
  inout  wire  [WIDTH-1:0]   bidir_port,
  output logic               irq
);

  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_clr;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             wr;
  logic [31:0]      rd_next;
  logic [31:0]      readdata_q;
  logic             unused_wd;

  pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bidir_port),
    .q     (sync_in)
  );

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  // Held off until the synchroniser and prev_in hold real pin values.
  assign armed     = (arm_cnt == ARM_DONE);
  assign edge_clr  = (wr && bus.address == ADDR_EDGECAP) ? wd : '0;

  always_comb begin
    edge_det = '0;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_det = sync_in & ~prev_in;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_det = ~sync_in & prev_in;
    end else begin
      edge_det = sync_in ^ prev_in;
    end
    if (!armed) begin
      edge_det = '0;
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = sync_in;
      ADDR_DIR:     rd_next[WIDTH-1:0] = dir;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      ADDR_OUTSET:  rd_next[WIDTH-1:0] = data_out;
      ADDR_OUTCLR:  rd_next[WIDTH-1:0] = data_out;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= OUT_RESET;
      dir        <= '0;
      irqmask    <= '0;
      edgecap    <= '0;
      prev_in    <= '0;
      arm_cnt    <= '0;
      readdata_q <= '0;
    end else begin
      readdata_q <= rd_next;
      prev_in    <= sync_in;
      // A new edge in the same cycle as a write-1-to-clear keeps the bit set.
      edgecap    <= (edgecap & ~edge_clr) | edge_det;
      if (!armed) begin
        arm_cnt <= arm_cnt + 3'd1;
      end
      if (wr) begin
        case (bus.address)
          ADDR_DATA:    data_out <= wd;
          ADDR_DIR:     dir      <= wd;
          ADDR_IRQMASK: irqmask  <= wd;
          ADDR_OUTSET:  data_out <= data_out | wd;
          ADDR_OUTCLR:  data_out <= data_out & ~wd;
          default:      ;
        endcase
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edgecap & irqmask);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    if (OPEN_DRAIN != 0) begin : g_od
      assign bidir_port[i] = (dir[i] & ~data_out[i]) ? 1'b0 : 1'bz;
    end else begin : g_pp
      assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
    end
  end

endmodule

// File: tb/tb_avalon_bidir_pio.sv
// Bench for avalon_bidir_pio: a push-pull/any-edge instance and an
// open-drain/rising-edge instance on pulled-up pins with external drivers.
module tb_avalon_bidir_pio;
  import avalon_pio_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avalon_bidir_pio_if if0 ();
  avalon_bidir_pio_if if1 ();

  wire  [7:0] pins0;
  wire  [7:0] pins1;
  logic [7:0] ext_en0, ext_val0, ext_en1, ext_val1;
  logic       irq0, irq1;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    pullup pu0 (pins0[i]);
    pullup pu1 (pins1[i]);
    assign pins0[i] = ext_en0[i] ? ext_val0[i] : 1'bz;
    assign pins1[i] = ext_en1[i] ? ext_val1[i] : 1'bz;
  end

  avalon_bidir_pio #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY), .OPEN_DRAIN(0), .OUT_RESET(8'h00)
  ) u_dut0 (
    .clk(clk), .reset(rst), .bus(if0), .bidir_port(pins0), .irq(irq0)
  );

  avalon_bidir_pio #(
    .WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(EDGE_RISE), .OPEN_DRAIN(1), .OUT_RESET(8'hFF)
  ) u_dut1 (
    .clk(clk), .reset(rst), .bus(if1), .bidir_port(pins1), .irq(irq1)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bus(input int d, input logic [2:0] a, input logic cs,
                           input logic wn, input logic [31:0] wdata);
    if (d == 0) begin
      if0.address = a; if0.chipselect = cs; if0.write_n = wn; if0.writedata = wdata;
    end else begin
      if1.address = a; if1.chipselect = cs; if1.write_n = wn; if1.writedata = wdata;
    end
  endtask

  function automatic logic [31:0] rdata(input int d);
    return (d == 0) ? if0.readdata : if1.readdata;
  endfunction

  task automatic bus_write(input int d, input logic [2:0] a, input logic [31:0] wdata);
    @(negedge clk);
    drive_bus(d, a, 1'b1, 1'b0, wdata);
    @(negedge clk);
    drive_bus(d, a, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic bus_read(input int d, input logic [2:0] a, input logic [31:0] exp,
                          input string tag);
    @(negedge clk);
    drive_bus(d, a, 1'b1, 1'b1, 32'h0);
    exp_q.push_back(exp);
    @(negedge clk);
    check(tag, rdata(d), exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_bus(0, ADDR_DATA, 1'b0, 1'b1, 32'h0);
    drive_bus(1, ADDR_DATA, 1'b0, 1'b1, 32'h0);
    ext_en0 = '0; ext_val0 = '0; ext_en1 = '0; ext_val1 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rdata0", if0.readdata, 32'h0);
    check("rst_irq0", {31'h0, irq0}, 32'h0);
    check("rst_pins0_z", {24'h0, pins0}, 32'hFF);
    check("rst_pins1_z", {24'h0, pins1}, 32'hFF);

    // Pins sit high out of reset: no capture during the arming window.
    drive_bus(0, ADDR_EDGECAP, 1'b1, 1'b1, 32'h0);
    drive_bus(1, ADDR_EDGECAP, 1'b1, 1'b1, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("arm_edgecap0_%0d", k), if0.readdata, 32'h0);
      check($sformatf("arm_edgecap1_%0d", k), if1.readdata, 32'h0);
      check($sformatf("arm_irq0_%0d", k), {31'h0, irq0}, 32'h0);
    end
    bus_read(0, ADDR_DATA, 32'hFF, "data0_pulled_high");
    bus_read(1, ADDR_OUTSET, 32'hFF, "out_reset1");

    // Direction and drive, with upper writedata bits ignored.
    ext_en0 = 8'hF0; ext_val0 = 8'h00;
    bus_write(0, ADDR_DIR, 32'hFFFF_FF0F);
    bus_write(0, ADDR_DATA, 32'h0000_00A5);
    check("pins0_drive", {24'h0, pins0}, 32'h05);
    ext_en0 = 8'h00;
    #1 check("pins0_upper_z", {24'h0, pins0}, 32'hF5);
    ext_en0 = 8'hF0;
    bus_read(0, ADDR_IRQMASK, 32'h0, "irqmask0_rst");
    drive_bus(0, ADDR_DIR, 1'b1, 1'b1, 32'h0);
    #1 check("dir0_latency_before", if0.readdata, 32'h0);
    @(negedge clk);
    check("dir0_latency_after", if0.readdata, 32'h0F);
    bus_read(0, ADDR_DATA, 32'h05, "data0_sync");

    // Atomic set / clear.
    bus_write(0, ADDR_DATA, 32'h0F);
    bus_write(0, ADDR_OUTSET, 32'hF0);
    bus_read(0, ADDR_OUTSET, 32'hFF, "outset0");
    bus_write(0, ADDR_OUTCLR, 32'h81);
    bus_read(0, ADDR_OUTCLR, 32'h7E, "outclr0");
    check("pins0_after_clr", {24'h0, pins0}, 32'h0E);

    // Unmapped address: reads zero, writes have no effect.
    bus_write(0, 3'd6, 32'hFFFF_FFFF);
    bus_read(0, 3'd6, 32'h0, "addr6_zero");
    bus_read(0, ADDR_DIR, 32'h0F, "dir0_after_addr6");
    bus_read(0, ADDR_IRQMASK, 32'h0, "irqmask0_after_addr6");
    bus_read(0, ADDR_OUTSET, 32'h7E, "dataout0_after_addr6");
    bus_read(0, ADDR_DATA, 32'h0E, "data0_after_clr");

    // Any-edge capture on dut0: both rising and falling on pin7.
    bus_write(0, ADDR_EDGECAP, 32'hFF);
    bus_read(0, ADDR_EDGECAP, 32'h0, "edgecap0_cleared");
    bus_write(0, ADDR_IRQMASK, 32'h80);
    ext_en0 = 8'h70;
    repeat (4) @(negedge clk);
    check("irq0_rise", {31'h0, irq0}, 32'h1);
    bus_read(0, ADDR_EDGECAP, 32'h80, "edgecap0_rise");
    bus_write(0, ADDR_EDGECAP, 32'h80);
    check("irq0_cleared", {31'h0, irq0}, 32'h0);
    ext_en0 = 8'hF0;
    repeat (4) @(negedge clk);
    check("irq0_fall", {31'h0, irq0}, 32'h1);
    bus_read(0, ADDR_EDGECAP, 32'h80, "edgecap0_fall");

    // Rising-only capture on dut1; falls ignored.
    ext_en1 = 8'hFF; ext_val1 = 8'h00;
    bus_write(1, ADDR_IRQMASK, 32'h02);
    repeat (5) @(negedge clk);
    bus_read(1, ADDR_EDGECAP, 32'h0, "edgecap1_fall_ignored");
    ext_en1 = 8'hFD;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("irq1_latency_%0d", k), {31'h0, irq1}, (k == 4) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    drive_bus(1, ADDR_EDGECAP, 1'b1, 1'b0, 32'h02);
    #1 check("irq1_before_clr", {31'h0, irq1}, 32'h1);
    @(negedge clk);
    drive_bus(1, ADDR_EDGECAP, 1'b1, 1'b1, 32'h0);
    check("irq1_after_clr", {31'h0, irq1}, 32'h0);
    ext_en1 = 8'hFC;
    repeat (5) @(negedge clk);
    check("irq1_pin0_masked", {31'h0, irq1}, 32'h0);
    bus_read(1, ADDR_EDGECAP, 32'h01, "edgecap1_pin0");

    // Edge lands on the same edge as a write-1 clear of the same bit.
    ext_en1 = 8'hFE;
    repeat (5) @(negedge clk);
    ext_en1 = 8'hFC;
    repeat (3) @(negedge clk);
    drive_bus(1, ADDR_EDGECAP, 1'b1, 1'b0, 32'h02);
    @(negedge clk);
    drive_bus(1, ADDR_EDGECAP, 1'b1, 1'b1, 32'h0);
    check("irq1_collision", {31'h0, irq1}, 32'h1);
    bus_read(1, ADDR_EDGECAP, 32'h03, "edgecap1_collision");

    // Open-drain drive on pin0.
    bus_write(1, ADDR_DIR, 32'h01);
    check("od_release_init", {24'h0, pins1}, 32'h03);
    bus_write(1, ADDR_OUTCLR, 32'h01);
    check("od_drive_low", {24'h0, pins1}, 32'h02);
    bus_write(1, ADDR_OUTSET, 32'h01);
    check("od_release", {24'h0, pins1}, 32'h03);
    ext_en1 = 8'hFD;
    repeat (4) @(negedge clk);
    bus_read(1, ADDR_DATA, 32'h02, "od_ext_low_data1");

    // Asynchronous reset in mid-operation.
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pins0", {24'h0, pins0}, 32'h0F);
    check("mid_rst_irq0", {31'h0, irq0}, 32'h0);
    check("mid_rst_rdata0", if0.readdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(0, ADDR_DIR, 32'h0, "dir0_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
